shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq_pkg.sv | 17 +
 rtl/shift_step.sv | 36 +++
 rtl/shift_seq.sv | 117 +++++++++++
 tb/tb_shift_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared shift-operation definitions: opcode width, mode encodings and
// the multi-bit step size used by the fast datapath.
package shift_seq_pkg;

  localparam int unsigned SHIFT_OPCODE_WIDTH = 2;

  typedef enum logic [SHIFT_OPCODE_WIDTH-1:0] {
    ShiftSll = 2'b00,
    ShiftSrl = 2'b01,
    ShiftRol = 2'b10,
    ShiftSra = 2'b11
  } shift_op_e;

  // Bits moved per cycle by the wide step.
  localparam int unsigned FAST_STEP = 4;

endpackage

// File: rtl/shift_step.sv
// Single-step combinational shifter: moves data by 1 bit, or by FAST_STEP
// bits when big is set, using the fill rule of the selected mode.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  shift_op_e             mode,
  input  logic                  big,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  // One step of the selected shift/rotate.
  always_comb begin
    data_out = data_in;
    if (!big) begin
      unique case (mode)
        ShiftSll: data_out = {data_in[DATA_WIDTH-2:0], 1'b0};
        ShiftSrl: data_out = {1'b0, data_in[DATA_WIDTH-1:1]};
        ShiftRol: data_out = {data_in[DATA_WIDTH-2:0], data_in[DATA_WIDTH-1]};
        ShiftSra: data_out = {data_in[DATA_WIDTH-1], data_in[DATA_WIDTH-1:1]};
        default:  data_out = data_in;
      endcase
    end else begin
      unique case (mode)
        ShiftSll: data_out = {data_in[DATA_WIDTH-5:0], 4'b0000};
        ShiftSrl: data_out = {4'b0000, data_in[DATA_WIDTH-1:4]};
        ShiftRol: data_out = {data_in[DATA_WIDTH-5:0], data_in[DATA_WIDTH-1:DATA_WIDTH-4]};
        ShiftSra: data_out = {{4{data_in[DATA_WIDTH-1]}}, data_in[DATA_WIDTH-1:4]};
        default:  data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter: accepts one request, shifts the operand a step per
// cycle under a down-counter, then holds the result until consumed.
// Optional feature: define SHIFT_SEQ_FAST_EN to step 4 bits per cycle while
// at least 4 bits remain.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SHIFT_OPCODE_WIDTH-1:0] mode,
  input  logic [SHIFT_WIDTH-1:0]        shift_amt,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          abort,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         data_out
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SHIFT_WIDTH-1:0]  cnt_q, cnt_d;
  shift_op_e               mode_q, mode_d;

  logic                    step_big;
  logic [SHIFT_WIDTH-1:0]  step_amt;
  logic [SHIFT_WIDTH-1:0]  cnt_next;
  logic [DATA_WIDTH-1:0]   step_data;

`ifdef SHIFT_SEQ_FAST_EN
  assign step_big = (cnt_q >= SHIFT_WIDTH'(FAST_STEP));
`else
  assign step_big = 1'b0;
`endif

  assign step_amt = step_big ? SHIFT_WIDTH'(FAST_STEP) : SHIFT_WIDTH'(1);
  assign cnt_next = cnt_q - step_amt;

  shift_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .mode    (mode_q),
    .big     (step_big),
    .data_in (data_q),
    .data_out(step_data)
  );

  // Next-state and handshake outputs; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mode_d  = shift_op_e'(mode);
          data_d  = data_in;
          cnt_d   = shift_amt;
          state_d = (shift_amt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d = step_data;
        cnt_d  = cnt_next;
        if (cnt_next == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Cancel keeps the last data value visible on data_out.
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      data_d  = data_q;
      mode_d  = mode_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= ShiftSll;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq (DATA_WIDTH=32): directed vectors with
// literal expectations plus a per-cycle comparison against a behavioural
// model built from arithmetic shifts and a latency countdown.
module tb_shift_seq;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [SW-1:0] shift_amt = '0;
  logic [W-1:0]  data_in = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  data_out;

  int checks = 0;
  int failures = 0;

  shift_seq #(
    .DATA_WIDTH (W),
    .SHIFT_WIDTH(SW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .shift_amt(shift_amt),
    .data_in  (data_in),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference result: a plain combinational shift by the full amount.
  function automatic logic [31:0] golden(input logic [1:0] m, input int a, input logic [31:0] d);
    logic signed [31:0] s;
    s = d;
    case (m)
      2'd0:    return d << a;
      2'd1:    return d >> a;
      2'd2:    return (a == 0) ? d : ((d << a) | (d >> (32 - a)));
      default: return s >>> a;
    endcase
  endfunction

  // Cycles from the accept cycle until out_valid is seen.
  function automatic int latency(input int a);
`ifdef SHIFT_SEQ_FAST_EN
    return (a == 0) ? 1 : 1 + (a >> 2) + (a & 3);
`else
    return 1 + a;
`endif
  endfunction

  // Behavioural model: 0 = accepting, 1 = busy, 2 = result held.
  int          m_state;
  int          m_wait;
  logic [31:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_wait  <= 0;
      m_res   <= '0;
    end else if (abort) begin
      m_state <= 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_res <= golden(mode, int'(shift_amt), data_in);
          if (latency(int'(shift_amt)) == 1) m_state <= 2;
          else begin
            m_state <= 1;
            m_wait  <= latency(int'(shift_amt)) - 1;
          end
        end
        1: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) m_state <= 2;
        end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready", in_ready, m_state == 0);
      check("model_out_valid", out_valid, m_state == 2);
      if (m_state == 2) check("model_data_out", data_out, m_res);
    end
  end

  task automatic start(input logic [1:0] m, input int a, input logic [31:0] d);
    @(posedge clk);
    #1;
    mode      = m;
    shift_amt = SW'(a);
    data_in   = d;
    in_valid  = 1'b1;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 64);
    if (!out_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_idle_after_ready"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [1:0] m, input int a,
                        input logic [31:0] d, input logic [31:0] exp, input int exp_lat);
    int lat;
    start(m, a, d);
    wait_done(name, lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_data"}, data_out, exp);
    release_result(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    int amts[7] = '{0, 1, 3, 4, 5, 16, 31};

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_data_out", data_out, 32'h0);
    rst_n = 1'b1;

`ifdef SHIFT_SEQ_FAST_EN
    run_op("sll31", 2'd0, 31, 32'h0000_0001, 32'h8000_0000, 11);
    run_op("sra4", 2'd3, 4, 32'h8000_0000, 32'hF800_0000, 2);
    run_op("srl4", 2'd1, 4, 32'h8000_0000, 32'h0800_0000, 2);
`else
    run_op("sll31", 2'd0, 31, 32'h0000_0001, 32'h8000_0000, 32);
    run_op("sra4", 2'd3, 4, 32'h8000_0000, 32'hF800_0000, 5);
    run_op("srl4", 2'd1, 4, 32'h8000_0000, 32'h0800_0000, 5);
`endif
    run_op("rol1", 2'd2, 1, 32'h8000_0001, 32'h0000_0003, 2);
    run_op("amt0", 2'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);

    // Back-pressure: result must hold while out_ready stays low.
    start(2'd2, 7, 32'h1234_5678);
    wait_done("stall", lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_data", data_out, 32'h1A2B_3C09);
      check("stall_in_ready", in_ready, 1'b0);
    end
    release_result("stall");
    check("stall_out_valid_drop", out_valid, 1'b0);

    // Abort in cycle N+3 of a 20-bit shift.
    start(2'd0, 20, 32'h0000_0001);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) in_valid = 1'b0;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    run_op("post_abort", 2'd1, 3, 32'h0000_00F0, 32'h0000_001E, 4);

    // Abort wins over a simultaneous request.
    @(posedge clk);
    #1;
    mode = 2'd0; shift_amt = SW'(9); data_in = 32'h5; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_priority_in_ready", in_ready, 1'b1);

    // Reset in cycle N+5 of a shift.
    start(2'd3, 25, 32'h8000_0000);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_data_out", data_out, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("rst_no_result", seen, 0);

    // Sweep of modes and amounts against the reference shift.
    for (int m = 0; m < 4; m++) begin
      for (int j = 0; j < 7; j++) begin
        run_op($sformatf("sweep_m%0d_a%0d", m, amts[j]), 2'(m), amts[j], 32'hA5C3_0F81,
               golden(2'(m), amts[j], 32'hA5C3_0F81), latency(amts[j]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
